// File: rtl/axi4_burst_master_pkg.sv
// Shared types for the AXI4 burst master: FSM states, response codes, 4 KB limit.
// Pure declarations, no logic and no latency.
// Backpressure is not applicable; the package carries no handshakes.
package axi4_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_ADDR = 3'd1,
    W_DATA = 3'd2,
    W_RESP = 3'd3,
    R_ADDR = 3'd4,
    R_DATA = 3'd5,
    DONE   = 3'd6
  } state_t;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  localparam int BOUNDARY_4K = 4096;

  // Severity order matches the encoding, so the worst response is the larger code.
  function automatic resp_t worst_resp(input resp_t a, input resp_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 INCR initiator: one command becomes AW/W/B or AR/R traffic.
// Latency: AW/ARVALID one cycle after cmd accept; single-beat write gives done 4 cycles after accept.
// Backpressure: W and R data pass straight through (wd_ready=WREADY, RREADY=rd_ready); AW/AR held until ready.
// Optional 4 KB crossing check when AXI_BOUNDARY_CHK_EN is defined.
module axi4_burst_master
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_WIDTH-1:0] wd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [7:0]            cnt_q;
  resp_t                 resp_q;
  logic                  perr_q;
  logic                  last_beat;
  logic                  cross_4k;

  assign last_beat = (cnt_q == len_q);

`ifdef AXI_BOUNDARY_CHK_EN
  logic [19:0] burst_end;
  assign burst_end = {8'd0, cmd_addr[11:0]} + (({12'd0, cmd_len} + 20'd1) << cmd_size);
  assign cross_4k  = (burst_end > 20'(BOUNDARY_4K));
`else
  assign cross_4k = 1'b0;
`endif

  // The master never increments addresses; the slave walks the burst itself.
  assign AWADDR = addr_q;
  assign AWLEN  = len_q;
  assign AWSIZE = size_q;
  assign ARADDR = addr_q;
  assign ARLEN  = len_q;
  assign ARSIZE = size_q;

  // State register; async reset abandons any burst in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and channel handshakes; data ports are combinational pass-throughs.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    WDATA     = '0;
    WLAST     = 1'b0;
    wd_ready  = 1'b0;
    BREADY    = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    rd_last   = 1'b0;
    done      = 1'b0;
    done_resp = RESP_OKAY;
    case (state)
      IDLE: begin
        cmd_ready = ~ARESET;
        if (cmd_valid && !ARESET) begin
          if (cross_4k)       state_nxt = DONE;
          else if (cmd_write) state_nxt = W_ADDR;
          else                state_nxt = R_ADDR;
        end
      end
      W_ADDR: begin
        AWVALID = 1'b1;
        if (AWREADY) state_nxt = W_DATA;
      end
      W_DATA: begin
        WVALID   = wd_valid;
        WDATA    = wd_data;
        WLAST    = last_beat;
        wd_ready = WREADY;
        if (wd_valid && WREADY && last_beat) state_nxt = W_RESP;
      end
      W_RESP: begin
        BREADY = 1'b1;
        if (BVALID) state_nxt = DONE;
      end
      R_ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_nxt = R_DATA;
      end
      R_DATA: begin
        RREADY   = rd_ready;
        rd_valid = RVALID;
        rd_data  = RDATA;
        rd_last  = RLAST;
        if (RVALID && rd_ready && RLAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        done_resp = perr_q ? RESP_SLVERR : resp_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture command fields, count beats and accumulate the worst burst response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      addr_q <= '0;
      len_q  <= '0;
      size_q <= '0;
      cnt_q  <= '0;
      resp_q <= RESP_OKAY;
      perr_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
            size_q <= cmd_size;
            cnt_q  <= '0;
            resp_q <= cross_4k ? RESP_SLVERR : RESP_OKAY;
            perr_q <= 1'b0;
          end
        end
        W_DATA: begin
          if (wd_valid && WREADY) cnt_q <= cnt_q + 8'd1;
        end
        W_RESP: begin
          if (BVALID) resp_q <= worst_resp(resp_q, BRESP);
        end
        R_DATA: begin
          if (RVALID && rd_ready) begin
            cnt_q  <= cnt_q + 8'd1;
            resp_q <= worst_resp(resp_q, RRESP);
            // A slave whose RLAST disagrees with the commanded length is flagged as SLVERR.
            if (RLAST != last_beat) perr_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/axi4_burst_master.md
Name: axi4_burst_master

Overview:
- Single-outstanding AXI4 initiator (INCR bursts only) that drives the team's AXI4 memory-mapped slave from a simple command port.
- Converts one command into AW/W/B or AR/R channel traffic.
- Streams write data in from, and read data out to, local valid/ready ports.
- Sits in the verification environment and SoC-level benches as the protocol-correct counterpart of the memory slave.

Parameters:
- DATA_WIDTH, 32, width of WDATA/RDATA and local data ports
- ADDR_WIDTH, 16, width of AWADDR/ARADDR and cmd_addr

Ports:
- ACLK  in  1  clock; all logic on its rising edge
- ARESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  master idle, command accepted on valid&ready
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  ADDR_WIDTH  start byte address
- cmd_len  in  8  beats-1 (AXI LEN encoding)
- cmd_size  in  3  bytes/beat = 2^size, must be <= log2(DATA_WIDTH/8)
- wd_valid / wd_ready  in / out  1  local write-data handshake
- wd_data  in  DATA_WIDTH  write beat
- rd_valid / rd_ready  out / in  1  local read-data handshake
- rd_data  out  DATA_WIDTH  read beat
- rd_last  out  1  final read beat
- done  out  1  one-cycle pulse at transaction end
- done_resp  out  2  worst response of the burst (max of BRESP or all RRESP)
- AWADDR, AWLEN[8], AWSIZE[3], AWVALID  out  write address channel; AWREADY in
- WDATA, WLAST, WVALID  out  write data channel; WREADY in
- BRESP[2], BVALID  in; BREADY out
- ARADDR, ARLEN[8], ARSIZE[3], ARVALID  out  read address channel; ARREADY in
- RDATA, RRESP[2], RLAST, RVALID  in; RREADY out

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all *VALID, BREADY, RREADY, done, rd_valid, wd_ready = 0.
  - Address/len/data outputs = 0; done_resp = 0; beat counter = 0.
- FSM states: IDLE, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register addr/len/size, clear resp accumulator, go to W_ADDR or R_ADDR.
  - cmd_ready=0 in every other state.
- W_ADDR:
  - AWVALID=1 with registered fields, entered the cycle after acceptance.
  - Held stable until AWREADY, then go to W_DATA.
  - AW and W are serialised: no WVALID before AW completes.
- W_DATA:
  - WVALID = wd_valid; WDATA = wd_data; wd_ready = WREADY (combinational pass-through, zero-latency).
  - Beat counter increments on WVALID&WREADY.
  - WLAST=1 when counter==len.
  - Last beat accepted -> W_RESP.
  - WVALID is never deasserted by the master once asserted unless the handshake completed (wd_valid must hold; that is a contract on the local source).
- W_RESP: BREADY=1; on BVALID capture BRESP -> DONE.
- R_ADDR: ARVALID=1 held until ARREADY -> R_DATA.
- R_DATA:
  - RREADY = rd_ready; rd_valid = RVALID; rd_data/rd_last pass through.
  - Each accepted beat ORs RRESP into the worst-response accumulator (max compare).
  - Beat accepted with RLAST -> DONE.
  - RLAST arriving before counter==len, or counter==len without RLAST: done_resp forced to 2'b10 (SLVERR); the FSM still exits on RLAST.
- DONE: done=1 for exactly one cycle with done_resp valid -> IDLE. Next command is accepted no earlier than the following cycle.
- Latency: at least 1 cycle from cmd acceptance to AW/ARVALID. A single-beat write with all readies high completes done 4 cycles after cmd handshake.
- Widths:
  - Beat counter is 8 bit; len=255 gives 256 beats without overflow.
  - Addresses are not incremented by the master; the slave computes beat addresses.
- Reset mid-burst: everything drops immediately. The partial burst is abandoned with no done pulse; the bench must also reset the slave.

Optional Feature:
- Macro AXI_BOUNDARY_CHK_EN.
- Defined:
  - In IDLE, a command whose burst would cross a 4 KB boundary is accepted but never issued: (addr[11:0] + (len+1)<<size) > 4096.
  - FSM goes straight to DONE with done_resp=2'b10.
  - No AW/AR/W traffic and no wd_ready assertion occur.
- Undefined: no check; any burst is issued as commanded.

Decomposition:
- Package axi4_pkg:
  - typedef enum for FSM states.
  - typedef for resp with constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Constant BOUNDARY_4K=4096.
  - Function worst_resp(a,b).
- No sub-module. The channels share one FSM and one counter, so a split adds only wiring.

Test Plan:
- Write cmd addr=0x0010, len=3, size=2, data 0xA0..0xA3, all readies high -> one AW (AWLEN=3, AWSIZE=2), four W beats, WLAST on 4th only, done with done_resp=00.
- Read back addr=0x0010, len=3 -> rd_data 0xA0..0xA3 in order, rd_last on 4th, done_resp=00.
- Random AWREADY/WREADY/RREADY stalls plus rd_ready low for 5 cycles mid-burst -> AW/W/AR fields stable while valid and not ready; no beat lost or duplicated.
- Slave returns RRESP=10 on beat 2 of a 4-beat read -> done_resp=10. A write with BRESP=10 -> done_resp=10.
- ARESET asserted during W_DATA beat 2 of len=7 -> same cycle WVALID=0, cmd_ready=0; after release, cmd_ready=1, no done pulse.
- With AXI_BOUNDARY_CHK_EN: cmd addr=0x0FF8, len=3, size=2 -> no AWVALID ever, done pulse with done_resp=10. Without the macro, the burst is issued.
